// File: rtl/uart_rx_buffer.sv
// 8N1 UART receiver feeding a show-ahead byte FIFO with sticky overrun and
// framing-error flags for a CPU that stalls while reading an empty buffer.
module uart_rx_buffer #(
  parameter int CLK_PER_HALF_BIT = 434,
  parameter int RX_SIZE          = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rxd,
  input  logic             is_in,
  input  logic             clr_err,
  output logic [31:0]      dout,
  output logic             rx_empty,
  output logic             stall,
  output logic [RX_SIZE:0] count,
  output logic             overrun,
  output logic             ferr
);

  localparam int CW    = $clog2(2 * CLK_PER_HALF_BIT) + 1;
  localparam int DEPTH = 2 ** RX_SIZE;
  localparam logic [CW-1:0]    HALF_LAST = CW'(CLK_PER_HALF_BIT - 1);
  localparam logic [CW-1:0]    FULL_LAST = CW'(2 * CLK_PER_HALF_BIT - 1);
  localparam logic [RX_SIZE:0] DEPTH_C   = (RX_SIZE + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic [7:0]          shift_q, shift_d;
  logic                meta_q, sync_q;
  logic                push_s, stop_err_s;
  logic                pop_s, full_s, wr_en_s, ovr_set_s;
  logic [RX_SIZE-1:0]  wrptr_q, wrptr_d, rdptr_q, rdptr_d;
  logic [RX_SIZE:0]    count_q, count_d;
  logic                overrun_q, overrun_d, ferr_q, ferr_d;
  logic [7:0]          mem [DEPTH];

  // Receiver next-state: counter restarts at every sample point.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    push_s     = 1'b0;
    stop_err_s = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = 3'd0;
        if (!sync_q) state_d = START;
        else         state_d = IDLE;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = sync_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {sync_q, shift_q[7:1]};
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (sync_q) push_s     = 1'b1;
          else        stop_err_s = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO bookkeeping: a pop at full frees the slot the same edge's push uses.
  always_comb begin
    pop_s     = is_in && (count_q != '0);
    full_s    = (count_q == DEPTH_C);
    wr_en_s   = push_s && (!full_s || pop_s);
    ovr_set_s = push_s && full_s && !pop_s;
    wrptr_d   = wr_en_s ? wrptr_q + RX_SIZE'(1) : wrptr_q;
    rdptr_d   = pop_s ? rdptr_q + RX_SIZE'(1) : rdptr_q;
    case ({wr_en_s, pop_s})
      2'b10:   count_d = count_q + (RX_SIZE + 1)'(1);
      2'b01:   count_d = count_q - (RX_SIZE + 1)'(1);
      default: count_d = count_q;
    endcase
    overrun_d = (overrun_q && !clr_err) || ovr_set_s;
    ferr_d    = (ferr_q && !clr_err) || stop_err_s;
  end

  // State, synchronizer and FIFO control registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q    <= 1'b1;
      sync_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      shift_q   <= 8'd0;
      wrptr_q   <= '0;
      rdptr_q   <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      meta_q    <= rxd;
      sync_q    <= meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      wrptr_q   <= wrptr_d;
      rdptr_q   <= rdptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      ferr_q    <= ferr_d;
    end
  end

  // Byte storage, deliberately left without reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) mem[wrptr_q] <= shift_q;
  end

  assign dout     = {24'd0, mem[rdptr_q]};
  assign rx_empty = (count_q == '0);
  assign stall    = is_in && rx_empty;
  assign count    = count_q;
  assign overrun  = overrun_q;
  assign ferr     = ferr_q;

endmodule
